// File: rtl/opc6_intc_pkg.sv
// Shared constants for the OPC6 interrupt controller: register offsets
// within the 8-word I/O window and the VECTOR "nothing active" code.
package opc6_intc_pkg;

  localparam logic [2:0] PEND_OFS  = 3'd0;
  localparam logic [2:0] MASK_OFS  = 3'd1;
  localparam logic [2:0] PRIO_OFS  = 3'd2;
  localparam logic [2:0] EDGE_OFS  = 3'd3;
  localparam logic [2:0] VEC_OFS   = 3'd4;
  localparam logic [2:0] SWSET_OFS = 3'd5;

  localparam logic [15:0] VEC_NONE = 16'h8000;

endpackage

// File: rtl/opc6_intc_sync.sv
// Two-flop synchronizer for a bus of independent asynchronous requests.
module opc6_intc_sync #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] s0;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      s0 <= '0;
      q  <= '0;
    end else begin
      s0 <= d;
      q  <= s0;
    end
  end

endmodule

// File: rtl/opc6_intc.sv
// OPC6 interrupt controller: synchronises up to 16 requests, holds them as
// pending, masks them and drives the CPU's two active-low interrupt lines.
module opc6_intc
  import opc6_intc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'hFE00,
  parameter int          NSRC      = 8
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic            clken,
  input  logic [15:0]     address,
  input  logic [15:0]     wdata,
  input  logic            rnw,
  input  logic            vio,
  input  logic [NSRC-1:0] irq_in,
  output logic [15:0]     rdata,
  output logic            sel,
  output logic [1:0]      int_b
);

  // Registers are held 16 wide; bits at or above NSRC are forced to zero.
  localparam logic [15:0] VALID = (NSRC >= 16) ? 16'hFFFF
                                               : 16'((32'd1 << NSRC) - 32'd1);

  function automatic logic [3:0] lowest_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  logic [NSRC-1:0] s1;
  logic [15:0]     s1_w, s2, pend, pend_nxt, mask, prio, edge_mode;
  logic [15:0]     rise, w1c, swset, active, hi_act, lo_act, wval;
  logic [2:0]      ofs;
  logic            wr;

  opc6_intc_sync #(.WIDTH(NSRC)) u_sync (
    .clk     (clk),
    .reset_b (reset_b),
    .d       (irq_in),
    .q       (s1)
  );

  assign s1_w   = 16'(s1);
  assign ofs    = address[2:0];
  assign sel    = vio && (address[15:3] == BASE_ADDR[15:3]);
  assign wr     = clken && sel && !rnw;
  assign wval   = wdata & VALID;
  assign w1c    = (wr && ofs == PEND_OFS)  ? wval : 16'h0000;
  assign swset  = (wr && ofs == SWSET_OFS) ? wval : 16'h0000;
  assign rise   = s1_w & ~s2;
  assign active = pend & mask;
  assign hi_act = active & prio;
  assign lo_act = active & ~prio;

  // Edge bits: a set in the same cycle as a clear wins, so no edge is lost.
  assign pend_nxt = VALID & ((edge_mode & ((pend & ~w1c) | rise | swset))
                           | (~edge_mode & s1_w));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      s2        <= '0;
      pend      <= '0;
      mask      <= '0;
      prio      <= '0;
      edge_mode <= '0;
      int_b     <= 2'b11;
    end else begin
      s2    <= s1_w;
      pend  <= pend_nxt;
      int_b <= {~|(pend & mask & prio), ~|(pend & mask & ~prio)};
      if (wr) begin
        case (ofs)
          MASK_OFS: mask      <= wval;
          PRIO_OFS: prio      <= wval;
          EDGE_OFS: edge_mode <= wval;
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = 16'h0000;
    if (sel) begin
      case (ofs)
        PEND_OFS: rdata = pend;
        MASK_OFS: rdata = mask;
        PRIO_OFS: rdata = prio;
        EDGE_OFS: rdata = edge_mode;
        VEC_OFS: begin
          if (active == 16'h0000)      rdata = VEC_NONE;
          else if (hi_act != 16'h0000) rdata = {12'h000, lowest_index(hi_act)};
          else                         rdata = {12'h000, lowest_index(lo_act)};
        end
        default: rdata = 16'h0000;
      endcase
    end
  end

endmodule
